// File: rtl/instr_mem_pkg.sv
// Shared constants for the instruction store: state encoding, default geometry, NOP word.
package instr_mem_pkg;

  localparam int DATA_W_DEF = 13;
  localparam int ADDR_W_DEF = 4;
  localparam int DEPTH_DEF  = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [DATA_W_DEF-1:0] NOP_WORD = '0;

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// Load and fetch bus of the instruction store; master is the loader/CPU side, slave is the store.
interface instr_mem_ctrl_if
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  // Load words move on LD_VALID & LD_READY; LD_READY never depends on LD_VALID.
  logic              LD_START;
  logic [ADDR_W-1:0] LD_BASE;
  logic [ADDR_W:0]   LD_LEN;
  logic              LD_VALID;
  logic [DATA_W-1:0] LD_DATA;
  logic              LD_READY;
  logic              LD_DONE;
  logic              FE_REQ;
  logic [ADDR_W-1:0] FE_ADDR;
  logic              FE_VALID;
  logic [DATA_W-1:0] FE_Q;
  logic              FE_ERR;
  logic              BUSY;

  modport master (
    output LD_START, LD_BASE, LD_LEN, LD_VALID, LD_DATA, FE_REQ, FE_ADDR,
    input  LD_READY, LD_DONE, FE_VALID, FE_Q, FE_ERR, BUSY
  );

  modport slave (
    input  LD_START, LD_BASE, LD_LEN, LD_VALID, LD_DATA, FE_REQ, FE_ADDR,
    output LD_READY, LD_DONE, FE_VALID, FE_Q, FE_ERR, BUSY
  );

endinterface

// File: rtl/instr_mem_array.sv
// DEPTH x DATA_W storage with synchronous write and registered read; never reset.
module instr_mem_array #(
  parameter int DATA_W = 13,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Read data holds between reads so the fetch port can present its last word.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction store controller: load FSM with wrapping burst writes, single-cycle fetch port.
module instr_mem_ctrl
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  instr_mem_ctrl_if.slave  bus,
  output logic [1:0]       dbg_state_o
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   rem_q, rem_d;
  logic              fe_valid_q, fe_valid_d;
  logic              fe_err_q, fe_err_d;
  logic              fe_zero_q, fe_zero_d;
  logic              load_start, wr_fire, fe_accept, fe_in_range;
  logic [ADDR_W-1:0] base_mod;
  logic [ADDR_W:0]   eff_len;
  logic [DATA_W-1:0] rdata;

  assign load_start  = (state_q == ST_IDLE) && bus.LD_START;
  assign wr_fire     = (state_q == ST_LOAD) && bus.LD_VALID;
  // A start in the same cycle wins over a fetch.
  assign fe_accept   = (state_q == ST_IDLE) && bus.FE_REQ && !bus.LD_START;
  assign fe_in_range = {1'b0, bus.FE_ADDR} < DEPTH_L;
  assign base_mod    = ADDR_W'({1'b0, bus.LD_BASE} % DEPTH_L);
  assign eff_len     = ((bus.LD_LEN == '0) || (bus.LD_LEN > DEPTH_L)) ? DEPTH_L : bus.LD_LEN;

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.LD_START) state_d = ST_LOAD;
      ST_LOAD: if (wr_fire && (rem_q == (ADDR_W+1)'(1))) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.LD_READY = (state_q == ST_LOAD);
    bus.LD_DONE  = (state_q == ST_DONE);
    bus.BUSY     = (state_q != ST_IDLE);
  end

  always_comb begin
    ptr_d = ptr_q;
    rem_d = rem_q;
    if (load_start) begin
      ptr_d = base_mod;
      rem_d = eff_len;
    end else if (wr_fire) begin
      ptr_d = (ptr_q == LAST_A) ? '0 : ptr_q + 1'b1;
      rem_d = rem_q - 1'b1;
    end
    fe_valid_d = fe_accept;
    fe_err_d   = fe_accept && !fe_in_range;
    // fe_zero forces FE_Q to zero after reset and after an out-of-range fetch.
    fe_zero_d  = fe_accept ? !fe_in_range : fe_zero_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q      <= '0;
      rem_q      <= '0;
      fe_valid_q <= 1'b0;
      fe_err_q   <= 1'b0;
      fe_zero_q  <= 1'b1;
    end else begin
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      fe_valid_q <= fe_valid_d;
      fe_err_q   <= fe_err_d;
      fe_zero_q  <= fe_zero_d;
    end
  end

  instr_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (wr_fire),
    .waddr_i (ptr_q),
    .wdata_i (bus.LD_DATA),
    .re_i    (fe_accept && fe_in_range),
    .raddr_i (bus.FE_ADDR),
    .rdata_o (rdata)
  );

  assign bus.FE_VALID = fe_valid_q;
  assign bus.FE_ERR   = fe_err_q;
  assign bus.FE_Q     = fe_zero_q ? '0 : rdata;
  assign dbg_state_o  = state_q;

endmodule
